// File: rtl/imem_access_arbiter_pkg.sv
`default_nettype none
// ---- imem_arb_pkg: shared types and constants for the imem access arbiter. Rev 1.0
package imem_arb_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam int DEPTH_DEFAULT = 256;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // Returned in place of memory data for out-of-range fetches.
  localparam logic [31:0] ERR_FILL = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_access_arbiter_if.sv
`default_nettype none
// ---- imem_access_arbiter_if: fetch, loader and memory-pin bundle around the arbiter. Rev 1.0
interface imem_access_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_flush;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              fetch_err;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              ld_gnt;
  logic              ld_err;

  logic              boot_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd_wrb;

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush,
    input  ld_req, ld_addr, ld_data, ld_done,
    input  mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
    output ld_gnt, ld_err, boot_done,
    output mem_addr, mem_wdata, mem_rd_wrb
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush,
    output ld_req, ld_addr, ld_data, ld_done,
    output mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
    input  ld_gnt, ld_err, boot_done,
    input  mem_addr, mem_wdata, mem_rd_wrb
  );

endinterface
`default_nettype wire

// File: rtl/imem_access_arbiter_rr_arb2.sv
`default_nettype none
// ---- rr_arb2: two-way round-robin arbiter; requester 0 wins the first conflict after reset. Rev 1.0
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // High when requester 1 received the most recent grant.
  logic last1_q;
  logic last1_d;

  assign gnt0_o = en_i & req0_i & (~req1_i | last1_q);
  assign gnt1_o = en_i & req1_i & (~req0_i | ~last1_q);

  always_comb begin
    last1_d = last1_q;
    if (gnt0_o | gnt1_o) begin
      last1_d = gnt1_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last1_q <= 1'b1;
    end else begin
      last1_q <= last1_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_access_arbiter.sv
`default_nettype none
// ---- imem_access_arbiter: boot sequencing and round-robin sharing of the instruction memory port. Rev 1.0
// Defining IMEM_ARB_WPROT_EN write-protects the memory once the arbiter is in RUN.
module imem_access_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  imem_access_arbiter_if.slave bus
);

  localparam logic [0:0]      ST_BOOT     = BOOT;
  localparam logic [0:0]      ST_RUN      = RUN;
  localparam logic [ADDR_W:0] c_depth_lim = (ADDR_W + 1)'(DEPTH);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              rvalid_q;
  logic              rvalid_d;
  logic              err_q;
  logic              err_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  logic w_run;
  logic w_fetch_cand;
  logic w_rr_fgnt;
  logic w_rr_lgnt;
  logic w_fetch_gnt;
  logic w_ld_gnt;
  logic w_fetch_oor;
  logic w_ld_oor;
  logic w_wprot;
  logic w_do_write;

  assign w_run = (state_q == ST_RUN);

`ifdef IMEM_ARB_WPROT_EN
  assign w_wprot = w_run;
`else
  assign w_wprot = 1'b0;
`endif

  assign w_fetch_oor = ({1'b0, bus.fetch_addr} >= c_depth_lim);
  assign w_ld_oor    = ({1'b0, bus.ld_addr} >= c_depth_lim);

  // A flush takes fetch out of contention so the loader can win that cycle.
  assign w_fetch_cand = bus.fetch_req & ~bus.fetch_flush;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (w_run),
    .req0_i (w_fetch_cand),
    .req1_i (bus.ld_req),
    .gnt0_o (w_rr_fgnt),
    .gnt1_o (w_rr_lgnt)
  );

  assign w_fetch_gnt = w_rr_fgnt;
  assign w_ld_gnt    = w_run ? w_rr_lgnt : bus.ld_req;
  assign w_do_write  = w_ld_gnt & ~w_ld_oor & ~w_wprot;

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_BOOT) && bus.ld_done) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    bus.mem_rd_wrb = RD;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (w_ld_gnt) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_data;
      if (w_do_write) begin
        bus.mem_rd_wrb = WR;
      end
    end else if (w_fetch_gnt) begin
      bus.mem_addr = bus.fetch_addr;
    end
  end

  always_comb begin
    rvalid_d = w_fetch_gnt;
    err_d    = w_fetch_gnt & w_fetch_oor;
    rdata_d  = rdata_q;
    if (w_fetch_gnt) begin
      rdata_d = w_fetch_oor ? DATA_W'(ERR_FILL) : bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.fetch_gnt    = w_fetch_gnt;
  assign bus.fetch_rvalid = rvalid_q & ~bus.fetch_flush;
  assign bus.fetch_err    = err_q & ~bus.fetch_flush;
  assign bus.fetch_rdata  = rdata_q;
  assign bus.ld_gnt       = w_ld_gnt;
  assign bus.ld_err       = w_ld_gnt & (w_ld_oor | w_wprot);
  assign bus.boot_done    = w_run;

endmodule
`default_nettype wire

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Sequences and shares the single-port instruction memory (10-bit address, 32-bit data, `rd_wrb` control, combinational read, write on rising edge when `rd_wrb`=0).
- Serves two requesters: the core fetch unit (read-only) and the program loader (write-only).
- Owns the boot phase: fetch is held off until the loader signals completion.
- After boot, both requesters share the port round-robin.
- Sits between fetch stage, loader and the instruction memory; it is the only driver of the memory's address, data and `rd_wrb` pins.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 32, instruction width.
- DEPTH, 256, number of implemented memory words; any address >= DEPTH is out of range.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_flush  in  1  kill the fetch response due this cycle; block any new fetch grant this cycle
- fetch_gnt  out  1  fetch accepted this cycle
- fetch_rvalid  out  1  fetch response valid
- fetch_rdata  out  DATA_W  fetched instruction
- fetch_err  out  1  response is for an out-of-range address (qualifies `fetch_rvalid`)
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- ld_done  in  1  single-cycle pulse: loading finished
- ld_gnt  out  1  write accepted this cycle
- ld_err  out  1  accepted write was out of range or blocked (valid with `ld_gnt`)
- boot_done  out  1  high in RUN state
- mem_addr  out  ADDR_W  to memory `addr`
- mem_wdata  out  DATA_W  to memory `data_in`
- mem_rdata  in  DATA_W  from memory `data_out`
- mem_rd_wrb  out  1  to memory `rd_wrb`; 1 = read, 0 = write

Behaviour:
- Reset values:
  - State = BOOT.
  - `fetch_gnt`, `fetch_rvalid`, `fetch_err`, `ld_gnt`, `ld_err`, `boot_done` = 0.
  - `fetch_rdata` = 0.
  - `mem_rd_wrb` = 1, `mem_addr` = 0, `mem_wdata` = 0.
- Reset mid-operation: any pending response is dropped and the state returns to BOOT. Memory contents are not touched.
- States:
  - BOOT: only the loader is served. `ld_gnt` = `ld_req`; `fetch_gnt` = 0.
    - `ld_done`=1 moves to RUN on the next cycle.
    - If `ld_req` and `ld_done` are high in the same cycle, the write is still served.
  - RUN: both requesters are served. `ld_done` is ignored. RUN persists until reset.
- RUN arbitration (2-way round-robin):
  - Single requester: it is granted.
  - Both requesting: grant the requester not granted last; the first conflict after reset goes to fetch.
  - The last-grant bit updates only on a grant.
- Grant timing:
  - Grants are combinational from the registered state and current requests.
  - The memory pins are driven combinationally from the winner:
    - Load grant: `mem_rd_wrb`=0, `mem_addr`=`ld_addr`, `mem_wdata`=`ld_data`.
    - Otherwise: `mem_rd_wrb`=1, `mem_addr`=`fetch_addr` (0 when idle), `mem_wdata`=0.
- Fetch latency:
  - A fetch accepted in cycle N produces `fetch_rvalid`=1 for exactly one cycle, N+1.
  - `fetch_rdata` = `mem_rdata` registered at the end of N, and holds until the next response.
  - Back-to-back fetches sustain one per cycle.
- Fetch flush:
  - `fetch_flush`=1 in cycle N forces `fetch_rvalid`=0 in N.
  - It also blocks `fetch_gnt` in N, so the loader may win N unopposed.
- Out-of-range fetch (`fetch_addr` >= DEPTH):
  - The fetch is still granted.
  - Response in N+1: `fetch_rvalid`=1, `fetch_err`=1, `fetch_rdata`=0.
- Out-of-range load (`ld_addr` >= DEPTH):
  - The load is granted with `ld_err`=1.
  - `mem_rd_wrb` stays 1, so no write occurs.
- Read-after-write: a fetch to an address written in cycle N, granted in N+1 or later, returns the new data.

Optional Feature:
- Macro: IMEM_ARB_WPROT_EN.
- With the macro defined: loads in RUN are still granted but flagged with `ld_err`=1, and `mem_rd_wrb` stays 1 (write suppressed). Loads in BOOT are unaffected.
- Without the macro: loads in RUN write normally under round-robin.

Decomposition:
- Package `imem_arb_pkg` holds:
  - the state enum (BOOT, RUN);
  - the constants DEPTH_DEFAULT=256 and RD=1'b1 / WR=1'b0;
  - the error-fill word (all zeros).
- One sub-module, `rr_arb2`: 2-way round-robin with a last-grant register, enable input and two grant outputs. It is instantiated for RUN-state arbitration.

Test Plan:
- Boot load: reset; in BOOT assert `fetch_req`@0 and loader writes 0x04610007@0, 0x08610002@1; `ld_done` pulse -> `fetch_gnt`=0 throughout BOOT; `boot_done`=1 the cycle after `ld_done`; fetch@1 returns 0x08610002 one cycle after grant.
- Streaming fetch: RUN, fetch addresses 0,1,2,3 on consecutive cycles -> four consecutive `fetch_rvalid` pulses carrying the stored words in order, with no bubbles.
- Contention: RUN, `fetch_req` and `ld_req` held high for 4 cycles -> grants alternate F,L,F,L. A fetch to the loaded address after the write returns the new data. With IMEM_ARB_WPROT_EN defined -> every load has `ld_err`=1 and memory is unchanged.
- Flush: fetch@2 granted in N, `fetch_flush`=1 in N+1 -> `fetch_rvalid`=0 in N+1 and no `fetch_gnt` in N+1.
- Range: fetch@300 -> `fetch_rvalid`=1, `fetch_err`=1, `fetch_rdata`=0. Load@512 -> `ld_gnt`=1, `ld_err`=1, `mem_rd_wrb` never 0.
- Reset mid-run: `rst` asserted in the cycle after a fetch grant -> `fetch_rvalid`=0 next cycle, state BOOT, `boot_done`=0; previously loaded words are still readable after the next `ld_done`.
